// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit/receive blocks.
package uart_pkg;
   localparam int SYS_CLK_HZ = 100_000_000;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_t;
   function automatic logic parity_on(input logic [1:0] m);
      return m == PAR_EVEN || m == PAR_ODD;
   endfunction
endpackage

// File: rtl/uart_tx_core_if.sv
// uart_tx_if: valid/ready word handshake into the transmitter.
interface uart_tx_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   modport master(output tx_data, tx_valid, input tx_ready);
   modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_core_baud_tick_gen.sv
// baud_tick_gen: loadable down-counter; bit_done is high once the loaded period has elapsed.
module baud_tick_gen #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 bit_done
);
   logic [DIV_WIDTH-1:0] cnt;
   assign bit_done = cnt == '0;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (load) cnt <= div - DIV_WIDTH'(1);
      else if (!bit_done) cnt <= cnt - DIV_WIDTH'(1);
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: single-clock UART transmitter; words accepted over valid/ready, sent LSB-first on txd.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 1042
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_tx_if.slave             tx,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic                 txd,
   output logic                 busy
);
   localparam int IW = $clog2(DATA_BITS);
   state_t state;
   logic [DATA_BITS-1:0] sh;
   logic [IW-1:0] idx;
   logic [DIV_WIDTH-1:0] div_l, div_c, div_sel;
   logic par, par_en, two_l, second, accept, bit_done, load;
   assign div_c   = (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div;
   assign accept  = tx.tx_valid && tx.tx_ready;
   // the counter is loaded from the live divider only on the accept edge
   assign div_sel = (state == IDLE) ? div_c : div_l;
   assign load    = accept || (state != IDLE && bit_done);
   baud_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
      .clk(clk), .rst(rst), .load(load), .div(div_sel), .bit_done(bit_done)
   );
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state       <= IDLE;
         txd         <= 1'b1;
         tx.tx_ready <= 1'b0;
         busy        <= 1'b0;
         sh          <= '0;
         idx         <= '0;
         par         <= 1'b0;
         par_en      <= 1'b0;
         two_l       <= 1'b0;
         second      <= 1'b0;
         div_l       <= DIV_WIDTH'(DEFAULT_DIV);
      end else case (state)
         IDLE: begin
            tx.tx_ready <= !accept;
            if (accept) begin
               state  <= START;
               txd    <= 1'b0;
               busy   <= 1'b1;
               sh     <= tx.tx_data;
               par    <= (^tx.tx_data) ^ (parity_mode == PAR_ODD);
               par_en <= parity_on(parity_mode);
               two_l  <= two_stop;
               second <= 1'b0;
               div_l  <= div_c;
            end
         end
         START: if (bit_done) begin
            state <= DATA;
            txd   <= sh[0];
            sh    <= sh >> 1;
            idx   <= '0;
         end
         DATA: if (bit_done) begin
            if (idx == IW'(DATA_BITS - 1)) begin
               state <= par_en ? PARITY : STOP;
               txd   <= par_en ? par : 1'b1;
            end else begin
               idx <= idx + IW'(1);
               txd <= sh[0];
               sh  <= sh >> 1;
            end
         end
         PARITY: if (bit_done) begin
            state <= STOP;
            txd   <= 1'b1;
         end
         STOP: if (bit_done) begin
            if (two_l && !second) second <= 1'b1;
            else begin
               state       <= IDLE;
               busy        <= 1'b0;
               tx.tx_ready <= 1'b1;
            end
         end
         default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed frames against hand-derived serial bit patterns.
module tb_uart_tx_core;
   import uart_pkg::*;
   logic clk = 1'b0, rst = 1'b0, two_stop = 1'b0, txd, busy;
   logic [15:0] div = 16'd4;
   logic [1:0] parity_mode = PAR_NONE;
   int n_cmp = 0, n_err = 0;
   uart_tx_if #(.DATA_BITS(8)) bus();
   uart_tx_core dut (
      .clk(clk), .rst(rst), .tx(bus), .div(div), .parity_mode(parity_mode),
      .two_stop(two_stop), .txd(txd), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic start(input logic [7:0] d8);
      int k = 0;
      bus.tx_data  = d8;
      bus.tx_valid = 1'b1;
      while (!bus.tx_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("accept_wait", bus.tx_ready, 1'b1);
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
   endtask
   task automatic check_frame(input logic [7:0] d8, input int d, input logic [1:0] pm,
                              input logic pbit, input logic ts, input string tag);
      logic [11:0] e;
      int n;
      e[0] = 1'b0;
      for (int i = 0; i < 8; i++) e[i+1] = d8[i];
      n = 9;
      if (pm == 2'd1 || pm == 2'd2) begin
         e[n] = pbit;
         n++;
      end
      e[n] = 1'b1;
      n++;
      if (ts) begin
         e[n] = 1'b1;
         n++;
      end
      for (int b = 0; b < n; b++)
         for (int c = 0; c < d; c++) begin
            @(negedge clk);
            chk($sformatf("%s_bit%0d_c%0d", tag, b, c), txd, e[b]);
            chk($sformatf("%s_busy%0d", tag, b), busy, 1'b1);
         end
      @(negedge clk);
      chk({tag, "_ready_after"}, bus.tx_ready, 1'b1);
      chk({tag, "_busy_after"}, busy, 1'b0);
      chk({tag, "_txd_after"}, txd, 1'b1);
   endtask
   initial begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h5A;
      repeat (5) begin
         @(negedge clk);
         chk("rst_txd", txd, 1'b1);
         chk("rst_ready", bus.tx_ready, 1'b0);
         chk("rst_busy", busy, 1'b0);
      end
      rst = 1'b1;
      bus.tx_valid = 1'b0;
      @(negedge clk);
      chk("rel_ready", bus.tx_ready, 1'b1);
      start(8'hA5);
      check_frame(8'hA5, 4, PAR_NONE, 1'b0, 1'b0, "basic");
      parity_mode = PAR_EVEN;
      start(8'hA5);
      check_frame(8'hA5, 4, PAR_EVEN, 1'b0, 1'b0, "even_a5");
      parity_mode = PAR_ODD;
      start(8'hA5);
      check_frame(8'hA5, 4, PAR_ODD, 1'b1, 1'b0, "odd_a5");
      parity_mode = PAR_EVEN;
      start(8'h07);
      check_frame(8'h07, 4, PAR_EVEN, 1'b1, 1'b0, "even_07");
      parity_mode = 2'd3;
      start(8'h81);
      check_frame(8'h81, 4, 2'd3, 1'b0, 1'b0, "mode3");
      parity_mode = PAR_NONE;
      two_stop = 1'b1;
      div = 16'd1;
      start(8'hFF);
      div = 16'd10;
      check_frame(8'hFF, 2, PAR_NONE, 1'b0, 1'b1, "clamp2stop");
      div = 16'd4;
      two_stop = 1'b0;
      bus.tx_data  = 8'h55;
      bus.tx_valid = 1'b1;
      @(posedge clk);
      #1 bus.tx_data = 8'hAA;
      check_frame(8'h55, 4, PAR_NONE, 1'b0, 1'b0, "b2b_55");
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
      check_frame(8'hAA, 4, PAR_NONE, 1'b0, 1'b0, "b2b_aa");
      start(8'hA5);
      repeat (18) @(negedge clk);
      chk("pre_rst_bit3", txd, 1'b0);
      #1 rst = 1'b0;
      #1;
      chk("midrst_txd", txd, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ready", bus.tx_ready, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_rel_ready", bus.tx_ready, 1'b1);
      start(8'h3C);
      check_frame(8'h3C, 4, PAR_NONE, 1'b0, 1'b0, "after_rst");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
